// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported data memory between the
// instruction-fetch requester (read only) and the load/store requester.
// The winning request is registered onto the memory port, held for MEM_LAT
// cycles, then completed with a one-cycle ack carrying the read data.
// ME has priority; IF is forced through after STARVE_LIMIT back-to-back ME
// grants made while IF was waiting.
// Optional build macro MEM_ARB_STATS_EN adds saturating 16-bit grant and
// conflict counters on three extra output ports.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        me_req,
    input  logic        me_wmem,
    input  logic [31:0] me_addr,
    input  logic [31:0] me_wdata,
    output logic        me_ack,
    output logic [31:0] me_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wmem,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0] stat_if_grants,
    output logic [15:0] stat_me_grants,
    output logic [15:0] stat_conflicts,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // Counter reload and starvation threshold, sized to the 4-bit counters
    // (both parameters are limited to 1..15).
    localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [3:0]  starve_q,    starve_d;
    logic        winner_me_q, winner_me_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wmem_q,  mem_wmem_d;
    logic        if_ack_q,    if_ack_d;
    logic        me_ack_q,    me_ack_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] me_rdata_q,  me_rdata_d;
    logic        grant_if;
    logic        grant_me;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_if_q,   stat_if_d;
    logic [15:0] stat_me_q,   stat_me_d;
    logic [15:0] stat_conf_q, stat_conf_d;

    function automatic logic [15:0] stat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Starvation count saturates at the limit so the forced IF grant stays
    // armed until IF actually wins.
    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        return (v == STARVE_MAX) ? v : v + 4'd1;
    endfunction

    // Arbitration, memory-port sequencing and ack/read-data generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        winner_me_d = winner_me_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmem_d  = mem_wmem_q;
        if_ack_d    = 1'b0;
        me_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        grant_if    = 1'b0;
        grant_me    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ME wins unless IF is waiting and has been passed over
                // STARVE_LIMIT times in a row.
                if (me_req && !(if_req && (starve_q == STARVE_MAX))) begin
                    grant_me = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end

                if (grant_me) begin
                    winner_me_d = 1'b1;
                    mem_addr_d  = me_addr;
                    mem_wdata_d = me_wdata;
                    mem_wmem_d  = me_wmem;
                    starve_d    = if_req ? starve_inc(starve_q) : 4'd0;
                    cnt_d       = LAT_RELOAD;
                    state_d     = ST_ACCESS;
                end else if (grant_if) begin
                    // Write data is left as-is on an IF grant; only the
                    // address and the write strobe matter for a fetch.
                    winner_me_d = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wmem_d  = 1'b0;
                    starve_d    = 4'd0;
                    cnt_d       = LAT_RELOAD;
                    state_d     = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Port is held stable; a write strobe held for several
                // cycles just rewrites the same word with the same data.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = ST_ACK;
                    mem_wmem_d = 1'b0;
                    if (winner_me_q) begin
                        me_ack_d = 1'b1;
                        if (!mem_wmem_q) begin
                            me_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end

            ST_ACK: begin
                // Ack lasts exactly one cycle; a request still high in the
                // following IDLE cycle is arbitrated as a new one.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    // Grant and conflict statistics, updated on every IDLE grant.
    always_comb begin
        stat_if_d   = stat_if_q;
        stat_me_d   = stat_me_q;
        stat_conf_d = stat_conf_q;
        if (grant_if) begin
            stat_if_d = stat_inc(stat_if_q);
        end
        if (grant_me) begin
            stat_me_d = stat_inc(stat_me_q);
        end
        if ((grant_if || grant_me) && if_req && me_req) begin
            stat_conf_d = stat_inc(stat_conf_q);
        end
    end

    // Statistics registers; cleared by reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stat_if_q   <= 16'd0;
            stat_me_q   <= 16'd0;
            stat_conf_q <= 16'd0;
        end else begin
            stat_if_q   <= stat_if_d;
            stat_me_q   <= stat_me_d;
            stat_conf_q <= stat_conf_d;
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_me_grants = stat_me_q;
    assign stat_conflicts = stat_conf_q;
`endif

    // State and datapath registers; reset abandons any access without an ack.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            starve_q    <= 4'd0;
            winner_me_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wmem_q  <= 1'b0;
            if_ack_q    <= 1'b0;
            me_ack_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            me_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            winner_me_q <= winner_me_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmem_q  <= mem_wmem_d;
            if_ack_q    <= if_ack_d;
            me_ack_q    <= me_ack_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign me_ack    = me_ack_q;
    assign if_rdata  = if_rdata_q;
    assign me_rdata  = me_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmem  = mem_wmem_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
